lowx_fetch_arbiter: RTL and testbench

//  Shares the single lower-level memory (lowX) port between the instruction align

---
 rtl/lowx_fetch_arbiter.sv | 129 ++++++++++++
 tb/tb_lowx_fetch_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lowx_fetch_arbiter.sv
// Round-robin arbiter sharing one lower-level memory port between the instruction
// align buffer (I, reads) and the data cache (D, reads/writes); one transaction in flight.
module lowx_fetch_arbiter #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned BLK_SIZE = 128,
   parameter int unsigned TIMEOUT  = 1024
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                i_req_valid_i,
   input  logic [XLEN-1:0]     i_req_addr_i,
   input  logic                i_req_uncached_i,
   output logic                i_rsp_valid_o,
   output logic [BLK_SIZE-1:0] i_rsp_blk_o,
   input  logic                d_req_valid_i,
   input  logic                d_req_we_i,
   input  logic [XLEN-1:0]     d_req_addr_i,
   input  logic [BLK_SIZE-1:0] d_req_wdata_i,
   input  logic                d_req_uncached_i,
   output logic                d_rsp_valid_o,
   output logic [BLK_SIZE-1:0] d_rsp_blk_o,
   output logic                mem_req_valid_o,
   input  logic                mem_req_ready_i,
   output logic                mem_req_we_o,
   output logic [XLEN-1:0]     mem_req_addr_o,
   output logic [BLK_SIZE-1:0] mem_req_wdata_o,
   output logic                mem_req_uncached_o,
   input  logic                mem_rsp_valid_i,
   input  logic [BLK_SIZE-1:0] mem_rsp_blk_i,
   output logic                busy_o,
   output logic                timeout_o
);

   localparam int unsigned OFFW = $clog2(BLK_SIZE / 8);
   localparam int unsigned CW   = $clog2(TIMEOUT);
   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN - OFFW){1'b1}}, {OFFW{1'b0}}};
   localparam logic [CW-1:0]   CNT_LAST   = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;

   state_t              state_q, state_d;
   owner_t              owner_q, last_q, pick;
   logic                we_q, unc_q, timeout_q;
   logic [XLEN-1:0]     addr_q;
   logic [BLK_SIZE-1:0] wdata_q;
   logic [CW-1:0]       cnt_q;
   logic                rsp_hit, to_hit, done;

   always_comb begin
      state_d = state_q;
      pick    = OWN_I;
      rsp_hit = 1'b0;
      to_hit  = 1'b0;
      // D wins when alone, or on a tie when I was served last
      if (d_req_valid_i && (!i_req_valid_i || last_q == OWN_I))
         pick = OWN_D;
      case (state_q)
         S_IDLE: if (i_req_valid_i || d_req_valid_i) state_d = S_REQ;
         S_REQ:  if (mem_req_ready_i) state_d = S_WAIT;
         S_WAIT: begin
            if (mem_rsp_valid_i) begin
               rsp_hit = 1'b1;
               state_d = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               to_hit  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         owner_q   <= OWN_I;
         last_q    <= OWN_D;
         we_q      <= 1'b0;
         unc_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (i_req_valid_i || d_req_valid_i) begin
                  owner_q <= pick;
                  last_q  <= pick;
                  if (pick == OWN_D) begin
                     addr_q  <= d_req_addr_i & ALIGN_MASK;
                     we_q    <= d_req_we_i;
                     wdata_q <= d_req_wdata_i;
                     unc_q   <= d_req_uncached_i;
                  end else begin
                     addr_q  <= i_req_addr_i & ALIGN_MASK;
                     we_q    <= 1'b0;
                     wdata_q <= '0;
                     unc_q   <= i_req_uncached_i;
                  end
               end
            end
            S_REQ:   cnt_q <= '0;
            S_WAIT:  cnt_q <= cnt_q + CW'(1);
            default: cnt_q <= '0;
         endcase
         if (to_hit)
            timeout_q <= 1'b1;
      end
   end

   // Timeout completes the transaction with a zero block so the requester never stalls
   assign done          = rsp_hit || to_hit;
   assign i_rsp_valid_o = done && (owner_q == OWN_I);
   assign d_rsp_valid_o = done && (owner_q == OWN_D);
   assign i_rsp_blk_o   = (rsp_hit && owner_q == OWN_I) ? mem_rsp_blk_i : '0;
   assign d_rsp_blk_o   = (rsp_hit && owner_q == OWN_D) ? mem_rsp_blk_i : '0;

   assign mem_req_valid_o    = (state_q == S_REQ);
   assign mem_req_we_o       = we_q;
   assign mem_req_addr_o     = addr_q;
   assign mem_req_wdata_o    = wdata_q;
   assign mem_req_uncached_o = unc_q;
   assign busy_o             = (state_q != S_IDLE);
   assign timeout_o          = timeout_q;

endmodule

// File: tb/tb_lowx_fetch_arbiter.sv
// Directed bench for lowx_fetch_arbiter: single reads/writes, contention,
// watchdog timeout, REQ-phase response rejection and mid-transaction reset.
module tb_lowx_fetch_arbiter;

   localparam int unsigned XLEN = 32;
   localparam int unsigned BLK  = 128;

   logic            clk = 1'b0;
   logic            rst;
   logic            i_req_valid, i_req_uncached, i_rsp_valid;
   logic [XLEN-1:0] i_req_addr;
   logic [BLK-1:0]  i_rsp_blk;
   logic            d_req_valid, d_req_we, d_req_uncached, d_rsp_valid;
   logic [XLEN-1:0] d_req_addr;
   logic [BLK-1:0]  d_req_wdata, d_rsp_blk;
   logic            mem_req_valid, mem_req_ready, mem_req_we, mem_req_uncached;
   logic [XLEN-1:0] mem_req_addr;
   logic [BLK-1:0]  mem_req_wdata;
   logic            mem_rsp_valid;
   logic [BLK-1:0]  mem_rsp_blk;
   logic            busy, timeout;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   lowx_fetch_arbiter #(.XLEN(XLEN), .BLK_SIZE(BLK), .TIMEOUT(8)) dut (
      .clk_i(clk), .rst_i(rst),
      .i_req_valid_i(i_req_valid), .i_req_addr_i(i_req_addr),
      .i_req_uncached_i(i_req_uncached),
      .i_rsp_valid_o(i_rsp_valid), .i_rsp_blk_o(i_rsp_blk),
      .d_req_valid_i(d_req_valid), .d_req_we_i(d_req_we), .d_req_addr_i(d_req_addr),
      .d_req_wdata_i(d_req_wdata), .d_req_uncached_i(d_req_uncached),
      .d_rsp_valid_o(d_rsp_valid), .d_rsp_blk_o(d_rsp_blk),
      .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
      .mem_req_we_o(mem_req_we), .mem_req_addr_o(mem_req_addr),
      .mem_req_wdata_o(mem_req_wdata), .mem_req_uncached_o(mem_req_uncached),
      .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_blk_i(mem_rsp_blk),
      .busy_o(busy), .timeout_o(timeout)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [BLK-1:0] got,
                            input logic [BLK-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Drives one transaction whose requests are already applied by the caller
   task automatic do_txn(input int ready_lat, input int rsp_lat, input logic [BLK-1:0] blk,
                         input logic exp_d, input logic [XLEN-1:0] exp_addr,
                         input logic exp_we, input logic [BLK-1:0] exp_wdata);
      for (int n = 0; n < 10 && mem_req_valid !== 1'b1; n++) step();
      check_vec("req_valid", mem_req_valid, 1);
      check_vec("req_addr", mem_req_addr, exp_addr);
      check_vec("req_we", mem_req_we, exp_we);
      check_vec("req_wdata", mem_req_wdata, exp_wdata);
      for (int k = 0; k < ready_lat; k++) begin
         mem_req_ready = 1'b0;
         step();
         check_vec("hold_valid", mem_req_valid, 1);
         check_vec("hold_addr", mem_req_addr, exp_addr);
         check_vec("hold_we", mem_req_we, exp_we);
         check_vec("hold_wdata", mem_req_wdata, exp_wdata);
      end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      check_vec("wait_busy", busy, 1);
      check_vec("wait_noreq", mem_req_valid, 0);
      for (int k = 0; k < rsp_lat; k++) begin
         check_vec("early_rsp", {i_rsp_valid, d_rsp_valid}, 0);
         step();
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_blk   = blk;
      #1;
      check_vec("rsp_owner", exp_d ? d_rsp_valid : i_rsp_valid, 1);
      check_vec("rsp_other", exp_d ? i_rsp_valid : d_rsp_valid, 0);
      check_vec("rsp_blk", exp_d ? d_rsp_blk : i_rsp_blk, blk);
      step();
      mem_rsp_valid = 1'b0;
      mem_rsp_blk   = '0;
      check_vec("post_idle", busy, 0);
      check_vec("post_rsp", {i_rsp_valid, d_rsp_valid}, 0);
   endtask

   initial begin
      rst = 1'b1;
      {i_req_valid, i_req_uncached, d_req_valid, d_req_we, d_req_uncached} = '0;
      i_req_addr = '0; d_req_addr = '0; d_req_wdata = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_blk = '0;
      step();
      check_vec("rst_busy", busy, 0);
      check_vec("rst_valids", {mem_req_valid, i_rsp_valid, d_rsp_valid}, 0);
      check_vec("rst_addr", mem_req_addr, 0);
      check_vec("rst_timeout", timeout, 0);
      step();
      rst = 1'b0;

      // single I read, ready immediate, response 3 cycles into WAIT_RSP
      i_req_valid = 1'b1; i_req_addr = 32'h0000_1236;
      do_txn(0, 3, {32{4'hA}}, 1'b0, 32'h0000_1230, 1'b0, '0);
      i_req_valid = 1'b0;

      // D write held off by ready for 4 cycles
      d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h0000_8004;
      d_req_wdata = {4{32'h1234_5678}};
      do_txn(4, 2, {32{4'h3}}, 1'b1, 32'h0000_8000, 1'b1, {4{32'h1234_5678}});
      d_req_valid = 1'b0; d_req_we = 1'b0;

      // contention: grants alternate I, D, I, D
      i_req_valid = 1'b1; i_req_addr = 32'h0000_2004;
      d_req_valid = 1'b1; d_req_addr = 32'h0000_3008; d_req_wdata = {4{32'hCAFE_F00D}};
      do_txn(0, 1, {4{32'h1111_1111}}, 1'b0, 32'h0000_2000, 1'b0, '0);
      do_txn(1, 0, {4{32'h2222_2222}}, 1'b1, 32'h0000_3000, 1'b0, {4{32'hCAFE_F00D}});
      do_txn(0, 2, {4{32'h3333_3333}}, 1'b0, 32'h0000_2000, 1'b0, '0);
      do_txn(2, 1, {4{32'h4444_4444}}, 1'b1, 32'h0000_3000, 1'b0, {4{32'hCAFE_F00D}});
      i_req_valid = 1'b0; d_req_valid = 1'b0;

      // ready and response together in REQ: response must be ignored
      i_req_valid = 1'b1; i_req_addr = 32'h0000_4000;
      for (int n = 0; n < 10 && mem_req_valid !== 1'b1; n++) step();
      check_vec("t6_req", mem_req_valid, 1);
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_blk = {4{32'h5555_5555}};
      #1;
      check_vec("t6_req_rsp", {i_rsp_valid, d_rsp_valid}, 0);
      step();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_blk = '0;
      check_vec("t6_wait", busy, 1);
      step();
      mem_rsp_valid = 1'b1; mem_rsp_blk = {4{32'h7777_7777}};
      #1;
      check_vec("t6_rsp", i_rsp_valid, 1);
      check_vec("t6_blk", i_rsp_blk, {4{32'h7777_7777}});
      step();
      mem_rsp_valid = 1'b0; mem_rsp_blk = '0; i_req_valid = 1'b0;
      check_vec("t6_idle", busy, 0);

      // watchdog: D read with no response for 8 WAIT_RSP cycles
      d_req_valid = 1'b1; d_req_addr = 32'h0000_9000;
      for (int n = 0; n < 10 && mem_req_valid !== 1'b1; n++) step();
      check_vec("t5_req", mem_req_valid, 1);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      for (int k = 0; k < 7; k++) begin
         check_vec("t5_norsp", {i_rsp_valid, d_rsp_valid, timeout}, 0);
         step();
      end
      check_vec("t5_pulse", d_rsp_valid, 1);
      check_vec("t5_blk0", d_rsp_blk, 0);
      check_vec("t5_ipulse", i_rsp_valid, 0);
      step();
      d_req_valid = 1'b0;
      check_vec("t5_flag", timeout, 1);
      check_vec("t5_idle", busy, 0);
      mem_rsp_valid = 1'b1; mem_rsp_blk = {32{4'hF}};
      #1;
      check_vec("t5_late", {i_rsp_valid, d_rsp_valid}, 0);
      step();
      mem_rsp_valid = 1'b0; mem_rsp_blk = '0;
      check_vec("t5_sticky", timeout, 1);

      // reset mid-WAIT_RSP, then a tie must go to I
      i_req_valid = 1'b1; i_req_addr = 32'h0000_5010;
      for (int n = 0; n < 10 && mem_req_valid !== 1'b1; n++) step();
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      step();
      check_vec("t1_busy_pre", busy, 1);
      rst = 1'b1;
      d_req_valid = 1'b1; d_req_addr = 32'h0000_6000;
      #1;
      check_vec("t1_busy", busy, 0);
      check_vec("t1_valids", {mem_req_valid, i_rsp_valid, d_rsp_valid}, 0);
      check_vec("t1_timeout", timeout, 0);
      step();
      rst = 1'b0;
      step();
      check_vec("t1_grant_valid", mem_req_valid, 1);
      check_vec("t1_grant_addr", mem_req_addr, 32'h0000_5010);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
